// File: rtl/mmcm_servo_pkg.sv
// Shared types and defaults for the MMCM phase-shift servo and its responder model.
package mmcm_servo_pkg;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_BUSY = 1'b1
    } ps_state_t;

    localparam int MMCM_PS_LATENCY_DEFAULT = 12;
    localparam int MMCM_PS_STEPS_DEFAULT   = 448;

    // Wide enough for PS_LATENCY-1 across the whole 2..255 latency range.
    localparam int PS_CNT_W = 8;

endpackage

// File: rtl/mmcm_ps_phase_acc.sv
// Modulo-STEPS_PER_PERIOD up/down phase accumulator with a one-cycle wrap pulse.
module mmcm_ps_phase_acc #(
    parameter int STEPS_PER_PERIOD = 448,
    parameter int PHASE_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    input  logic               dir,
    output logic [PHASE_W-1:0] pos,
    output logic               wrap
);

    localparam logic [PHASE_W-1:0] POS_MAX = PHASE_W'(STEPS_PER_PERIOD - 1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (step_en) begin
                if (dir) begin
                    if (pos == POS_MAX) begin
                        pos  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        pos <= pos + PHASE_W'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        pos  <= POS_MAX;
                        wrap <= 1'b1;
                    end else begin
                        pos <= pos - PHASE_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mmcm_ps_responder.sv
// Responder side of the MMCM PSEN/PSINCDEC/PSDONE handshake with a phase position readout.
// Optional macro MMCM_PS_LOCK_GATE_EN adds locked_in gating of requests.
module mmcm_ps_responder
    import mmcm_servo_pkg::*;
#(
    parameter int PS_LATENCY       = MMCM_PS_LATENCY_DEFAULT,
    parameter int STEPS_PER_PERIOD = MMCM_PS_STEPS_DEFAULT,
    parameter int PHASE_W          = 16
) (
    input  logic               clk_in,
    input  logic               reset_in,
`ifdef MMCM_PS_LOCK_GATE_EN
    input  logic               locked_in,
`endif
    input  logic               psen_in,
    input  logic               psincdec_in,
    output logic               psdone_out,
    output logic               ps_busy_out,
    output logic [PHASE_W-1:0] phase_pos_out,
    output logic               wrap_out,
    output logic               err_overlap_out
);

    localparam logic [PS_CNT_W-1:0] CNT_LOAD = PS_CNT_W'(PS_LATENCY - 1);
    localparam logic [PS_CNT_W-1:0] CNT_ONE  = PS_CNT_W'(1);

    ps_state_t           state, state_nxt;
    logic [PS_CNT_W-1:0] cnt, cnt_nxt;
    logic                dir_q, dir_nxt;
    logic                err_q, err_nxt;
    logic                psdone_q, psdone_nxt;
    logic                step_en;
    logic                lock_ok;

`ifdef MMCM_PS_LOCK_GATE_EN
    assign lock_ok = locked_in;
`else
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= PS_IDLE;
            cnt      <= '0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            psdone_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dir_q    <= dir_nxt;
            err_q    <= err_nxt;
            psdone_q <= psdone_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dir_nxt    = dir_q;
        err_nxt    = err_q;
        psdone_nxt = 1'b0;
        step_en    = 1'b0;

        case (state)
            PS_IDLE: begin
                if (psen_in) begin
                    if (lock_ok) begin
                        state_nxt = PS_BUSY;
                        cnt_nxt   = CNT_LOAD;
                        dir_nxt   = psincdec_in;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            PS_BUSY: begin
                // Any request while busy, including the PSDONE cycle, is dropped.
                if (psen_in) begin
                    err_nxt = 1'b1;
                end
                if (!lock_ok || cnt == '0) begin
                    state_nxt = PS_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                    // Step one cycle early so position and PSDONE appear together.
                    if (cnt == CNT_ONE) begin
                        step_en    = 1'b1;
                        psdone_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = PS_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    mmcm_ps_phase_acc #(
        .STEPS_PER_PERIOD(STEPS_PER_PERIOD),
        .PHASE_W         (PHASE_W)
    ) u_phase_acc (
        .clk    (clk_in),
        .rst    (reset_in),
        .step_en(step_en),
        .dir    (dir_q),
        .pos    (phase_pos_out),
        .wrap   (wrap_out)
    );

    assign psdone_out      = psdone_q;
    assign ps_busy_out     = (state == PS_BUSY);
    assign err_overlap_out = err_q;

endmodule

// File: doc/mmcm_ps_responder.md
Name: mmcm_ps_responder

Overview:
- Synthesizable model of the MMCM dynamic phase-shift port (PSEN/PSINCDEC/PSDONE), acting as the responder end of the phase-shift handshake driven by the MMCM servo.
- Used two ways:
  - In simulation and hardware self-test, it stands in for a real MMCM so servo control loops can be exercised deterministically.
  - It exposes the accumulated phase position for checking.
- Sits on the PSCLK domain beside the servo controller.

Parameters:
- PS_LATENCY, 12, cycles from accepted PSEN to the PSDONE pulse; legal range 2..255.
- STEPS_PER_PERIOD, 448, phase steps per output-clock period; the accumulator is modulo this value; must be >=2.
- PHASE_W, 16, width of the phase position output; must satisfy 2**PHASE_W >= STEPS_PER_PERIOD.

Ports:
- clk_in  input  1  phase-shift clock (PSCLK); all logic on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- psen_in  input  1  phase-shift request, single-cycle strobe.
- psincdec_in  input  1  direction, sampled with psen_in: 1 = increment, 0 = decrement.
- psdone_out  output  1  one-cycle completion pulse.
- ps_busy_out  output  1  high while a request is outstanding.
- phase_pos_out  output  PHASE_W  current phase position, 0..STEPS_PER_PERIOD-1.
- wrap_out  output  1  one-cycle pulse when the position wraps in either direction.
- err_overlap_out  output  1  sticky flag: psen_in seen while busy.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on reset_in.
- Reset values: all outputs are 0; state = IDLE; latency counter = 0; captured direction = 0.
- State machine: IDLE and BUSY.
  - IDLE -> BUSY: psen_in=1 at edge T.
    - Capture psincdec_in.
    - Load the counter with PS_LATENCY-1.
    - ps_busy_out=1 from T+1.
  - BUSY: the counter decrements every cycle.
  - BUSY -> IDLE: when the counter reaches 0 and the last BUSY cycle ends.
    - psdone_out=1 for exactly one cycle, visible at T+PS_LATENCY.
    - phase_pos_out is updated in that same cycle.
    - ps_busy_out falls in the cycle after psdone_out.
- Latency: the psdone_out pulse is exactly PS_LATENCY cycles after the accepting psen_in edge, with no variation.
- Phase arithmetic:
  - Increment: phase_pos_out == STEPS_PER_PERIOD-1 -> 0, with wrap_out=1 in the psdone_out cycle.
  - Decrement: phase_pos_out == 0 -> STEPS_PER_PERIOD-1, with wrap_out=1.
  - Otherwise the position moves by ±1 and wrap_out stays 0.
  - No saturation.
- Overlap: psen_in=1 while BUSY, including the psdone_out cycle itself:
  - The request is ignored: no extra psdone_out, no phase change.
  - err_overlap_out is set and held until reset_in.
- Back-to-back: the earliest legal new psen_in is the cycle after psdone_out (state IDLE). It is accepted normally, giving a throughput of one step per PS_LATENCY+1 cycles.
- psincdec_in is ignored when psen_in=0.
- Reset mid-operation: the outstanding request is aborted and no psdone_out is generated. Position returns to 0 and err_overlap_out is cleared.
- psen_in held high for several cycles: the first edge is accepted; the remaining cycles count as overlaps.

Optional Feature:
- Macro: MMCM_PS_LOCK_GATE_EN.
- Defined:
  - Adds input locked_in (1 bit).
  - psen_in arriving in IDLE while locked_in=0 is rejected: no BUSY, no psdone_out, and err_overlap_out is set.
  - locked_in falling during BUSY aborts the request: the state returns to IDLE next cycle with no psdone_out and no phase change.
- Not defined: no locked_in port; every psen_in in IDLE is accepted.

Decomposition:
- Package mmcm_servo_pkg holds:
  - the ps_state_t enum {PS_IDLE, PS_BUSY};
  - the constants MMCM_PS_LATENCY_DEFAULT=12 and MMCM_PS_STEPS_DEFAULT=448.
- Sub-module mmcm_ps_phase_acc: modulo up/down accumulator with inputs step_en and dir, and outputs pos and wrap pulse. Parameters are STEPS_PER_PERIOD and PHASE_W.
- The handshake FSM and latency counter stay in the top module.

Test Plan:
- Single increment: reset, psen_in=1 with psincdec_in=1 at cycle 10 -> psdone_out only at cycle 22, phase_pos_out=1, ps_busy_out high for cycles 11..22.
- Decrement wrap: from reset, one decrement request -> phase_pos_out=447 and wrap_out=1 in the psdone_out cycle only.
- Increment wrap: 448 back-to-back increments, each issued the cycle after psdone_out -> phase_pos_out=0 after the last, exactly one wrap_out pulse, each psdone_out spaced 13 cycles apart.
- Overlap: second psen_in at T+5, then another coincident with psdone_out -> single psdone_out, phase +1, err_overlap_out=1 and held.
- Reset mid-operation: psen_in at T, reset_in at T+6 -> no psdone_out, phase_pos_out=0, ps_busy_out=0 at T+7; a new request afterwards completes normally.
- With MMCM_PS_LOCK_GATE_EN:
  - locked_in=0 when psen_in arrives -> rejected, err_overlap_out=1.
  - locked_in dropped at T+4 -> no psdone_out, phase unchanged.
